demorgan_sweep_checker: RTL and testbench

Parametrised, sequential successor to the three-input De Morgan gates. On a start request the block sweeps every N-bit input pattern, evaluates the gate-level form and the De Morgan-transformed form of the selected identity, compares them each cycle, and reports the pass/fail result, the mismatch count and the first failing pattern. It is used as a self-checking lab fixture, and a fault-injection hook proves that the checker itself detects errors.

---
 rtl/demorgan_sweep_checker_pkg.sv | 17 +
 rtl/demorgan_sweep_checker_eval.sv | 47 ++++
 rtl/demorgan_sweep_checker.sv | 125 ++++++++++++
 tb/tb_demorgan_sweep_checker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/demorgan_sweep_checker_pkg.sv
// Shared encodings for the De Morgan sweep checker: identity selectors and FSM states.
package demorgan_defs;

    typedef enum logic [1:0] {
        MODE_NAND    = 2'd0,
        MODE_NOR     = 2'd1,
        MODE_AOI     = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/demorgan_sweep_checker_eval.sv
// Combinational evaluator: gate-level form g and De Morgan form t of the selected identity,
// with an optional inversion of g at one pattern to prove the checker catches errors.
module demorgan_eval
    import demorgan_defs::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] x,
    input  logic [1:0]   mode,
    input  logic         fault_en,
    input  logic [N-1:0] fault_pat,
    output logic         g,
    output logic         t,
    output logic         mismatch
);

    logic g_raw;
    logic fault_hit;

    always_comb begin
        g_raw = 1'b0;
        t     = 1'b0;
        case (mode)
            MODE_NAND: begin
                g_raw = ~(&x);
                t     = |(~x);
            end
            MODE_NOR: begin
                g_raw = ~(|x);
                t     = &(~x);
            end
            MODE_AOI: begin
                g_raw = ~((&x[N-1:1]) | x[0]);
                t     = (|(~x[N-1:1])) & ~x[0];
            end
            default: begin
                g_raw = 1'b0;
                t     = 1'b0;
            end
        endcase
    end

    assign fault_hit = fault_en && (x == fault_pat);
    assign g         = g_raw ^ fault_hit;
    assign mismatch  = g ^ t;

endmodule

// File: rtl/demorgan_sweep_checker.sv
// Sweeps all N-bit patterns through demorgan_eval, counting mismatches and capturing the
// lowest failing pattern; all outputs are registered.
module demorgan_sweep_checker
    import demorgan_defs::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [1:0]   mode,
    input  logic         fault_en,
    input  logic [N-1:0] fault_pat,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         pass,
    output logic [N:0]   mismatch_cnt,
    output logic [N-1:0] first_fail,
    output logic [N-1:0] cur_pat
);

    localparam logic [N-1:0] LAST = '1;

    state_e       state;
    state_e       state_nxt;
    logic [1:0]   mode_q;
    logic         fault_en_q;
    logic [N-1:0] fault_pat_q;
    logic         g;
    logic         t;
    logic         mismatch;
    logic         unused_eval;
    logic         accept;
    logic         reject;
    logic [N:0]   cnt_nxt;

    demorgan_eval #(.N(N)) u_eval (
        .x        (cur_pat),
        .mode     (mode_q),
        .fault_en (fault_en_q),
        .fault_pat(fault_pat_q),
        .g        (g),
        .t        (t),
        .mismatch (mismatch)
    );

    // g and t are only observed here through their comparison
    assign unused_eval = g ^ t;
    assign cnt_nxt     = mismatch_cnt + {{N{1'b0}}, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (mode == MODE_ILLEGAL) begin
                        reject = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = S_SWEEP;
                    end
                end
            end
            S_SWEEP: begin
                if (abort)                state_nxt = S_IDLE;
                else if (cur_pat == LAST) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            cur_pat      <= '0;
            mode_q       <= MODE_NAND;
            fault_en_q   <= 1'b0;
            fault_pat_q  <= '0;
        end else begin
            done <= 1'b0;
            err  <= reject;
            if (accept) begin
                mode_q       <= mode;
                fault_en_q   <= fault_en;
                fault_pat_q  <= fault_pat;
                cur_pat      <= '0;
                mismatch_cnt <= '0;
                first_fail   <= '0;
                pass         <= 1'b0;
                busy         <= 1'b1;
            end else if (state == S_SWEEP) begin
                // abort freezes the partial results without scoring the current pattern
                if (abort) begin
                    busy <= 1'b0;
                end else begin
                    mismatch_cnt <= cnt_nxt;
                    if (mismatch && (mismatch_cnt == '0)) first_fail <= cur_pat;
                    if (cur_pat == LAST) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (cnt_nxt == '0);
                    end else begin
                        cur_pat <= cur_pat + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Directed bench for demorgan_sweep_checker with an N=3 and an N=8 instance.
module tb_demorgan_sweep_checker;

    logic clk;
    logic rst_n;

    logic       a_start, a_abort, a_fen;
    logic [1:0] a_mode;
    logic [2:0] a_fpat;
    logic       a_busy, a_done, a_err, a_pass;
    logic [3:0] a_cnt;
    logic [2:0] a_ff, a_cur;

    logic       b_start, b_abort, b_fen;
    logic [1:0] b_mode;
    logic [7:0] b_fpat;
    logic       b_busy, b_done, b_err, b_pass;
    logic [8:0] b_cnt;
    logic [7:0] b_ff, b_cur;

    int total = 0;
    int bad   = 0;

    demorgan_sweep_checker #(.N(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .mode(a_mode),
        .fault_en(a_fen), .fault_pat(a_fpat), .busy(a_busy), .done(a_done), .err(a_err),
        .pass(a_pass), .mismatch_cnt(a_cnt), .first_fail(a_ff), .cur_pat(a_cur)
    );

    demorgan_sweep_checker #(.N(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .mode(b_mode),
        .fault_en(b_fen), .fault_pat(b_fpat), .busy(b_busy), .done(b_done), .err(b_err),
        .pass(b_pass), .mismatch_cnt(b_cnt), .first_fail(b_ff), .cur_pat(b_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a sweep on the N=3 instance and wait (bounded) for done.
    task automatic run_a(input logic [1:0] m, input logic fe, input logic [2:0] fp,
                         output int lat, output int bcy);
        a_mode = m; a_fen = fe; a_fpat = fp; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        lat = -1;
        bcy = 0;
        for (int i = 0; i < 40; i++) begin
            if (a_done) begin
                lat = i + 1;
                break;
            end
            if (a_busy) bcy++;
            tick();
        end
    endtask

    initial begin
        int lat, bcy, saw;
        rst_n = 1'b0;
        a_start = 0; a_abort = 0; a_fen = 0; a_mode = 0; a_fpat = 0;
        b_start = 0; b_abort = 0; b_fen = 0; b_mode = 0; b_fpat = 0;
        #1;
        chk("reset_busy", {31'd0, a_busy}, 32'd0);
        chk("reset_done_err_pass", {29'd0, a_done, a_err, a_pass}, 32'd0);
        chk("reset_cnt", {28'd0, a_cnt}, 32'd0);
        chk("reset_ff_cur", {26'd0, a_ff, a_cur}, 32'd0);
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // mode 0, no fault
        run_a(2'd0, 1'b0, 3'd0, lat, bcy);
        chk("m0_latency", lat, 32'd9);
        chk("m0_busy_cycles", bcy, 32'd8);
        chk("m0_pass", {31'd0, a_pass}, 32'd1);
        chk("m0_cnt", {28'd0, a_cnt}, 32'd0);
        chk("m0_ff", {29'd0, a_ff}, 32'd0);
        chk("m0_busy_at_done", {31'd0, a_busy}, 32'd0);

        // mode 2 (AOI), fault at 5
        tick();
        run_a(2'd2, 1'b1, 3'd5, lat, bcy);
        chk("aoi_latency", lat, 32'd9);
        chk("aoi_pass", {31'd0, a_pass}, 32'd0);
        chk("aoi_cnt", {28'd0, a_cnt}, 32'd1);
        chk("aoi_ff", {29'd0, a_ff}, 32'd5);
        tick();
        chk("aoi_done_one_cycle", {31'd0, a_done}, 32'd0);

        // illegal mode
        a_mode = 2'd3; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("ill_err", {31'd0, a_err}, 32'd1);
        chk("ill_busy", {31'd0, a_busy}, 32'd0);
        tick();
        chk("ill_err_drop", {31'd0, a_err}, 32'd0);
        chk("ill_busy_still", {31'd0, a_busy}, 32'd0);
        chk("ill_cnt_kept", {28'd0, a_cnt}, 32'd1);
        chk("ill_ff_kept", {29'd0, a_ff}, 32'd5);
        chk("ill_pass_kept", {31'd0, a_pass}, 32'd0);

        // mode 1, fault at 6, abort at cur_pat 4
        a_mode = 2'd1; a_fen = 1'b1; a_fpat = 3'd6; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("abort_cur4", {29'd0, a_cur}, 32'd4);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        chk("abort_busy", {31'd0, a_busy}, 32'd0);
        chk("abort_pass", {31'd0, a_pass}, 32'd0);
        chk("abort_cnt", {28'd0, a_cnt}, 32'd0);
        saw = 0;
        for (int i = 0; i < 12; i++) begin
            if (a_done) saw++;
            tick();
        end
        chk("abort_no_done", saw, 32'd0);
        run_a(2'd1, 1'b1, 3'd6, lat, bcy);
        chk("rerun_latency", lat, 32'd9);
        chk("rerun_cnt", {28'd0, a_cnt}, 32'd1);
        chk("rerun_ff", {29'd0, a_ff}, 32'd6);
        chk("rerun_pass", {31'd0, a_pass}, 32'd0);

        // N=8, mode 1, fault at FF, stray start mid-sweep
        b_mode = 2'd1; b_fen = 1'b1; b_fpat = 8'hFF; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            if (b_done) begin
                lat = i + 1;
                break;
            end
            b_start = (i == 100);
            b_mode  = (i == 100) ? 2'd0 : 2'd1;
            tick();
        end
        b_start = 1'b0;
        chk("n8_latency", lat, 32'd257);
        chk("n8_cnt", {23'd0, b_cnt}, 32'd1);
        chk("n8_ff", {24'd0, b_ff}, 32'hFF);
        chk("n8_pass", {31'd0, b_pass}, 32'd0);
        tick(); tick();
        chk("n8_no_queued_start", {31'd0, b_busy}, 32'd0);

        // async reset mid-sweep, mode 1 with fault at 1
        tick();
        a_mode = 2'd1; a_fen = 1'b1; a_fpat = 3'd1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick(); tick(); tick();
        chk("rst_pre_cur", {29'd0, a_cur}, 32'd3);
        chk("rst_pre_cnt", {28'd0, a_cnt}, 32'd1);
        chk("rst_pre_ff", {29'd0, a_ff}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_async_cur", {29'd0, a_cur}, 32'd0);
        chk("rst_async_cnt", {28'd0, a_cnt}, 32'd0);
        chk("rst_async_ff", {29'd0, a_ff}, 32'd0);
        chk("rst_async_flags", {29'd0, a_done, a_err, a_pass}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_a(2'd0, 1'b0, 3'd0, lat, bcy);
        chk("post_rst_latency", lat, 32'd9);
        chk("post_rst_pass", {31'd0, a_pass}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
